// File: rtl/decode_stage.sv
// decode_stage: registered RV32 decode stage between fetch and the register file / ALU.
// Decodes each accepted instruction into register indices, instruction type, a sign-extended
// immediate and {opcode, funct3, funct7} control. The results go into a small output FIFO.
// Also provides flush, illegal-opcode flagging and a saturating illegal-instruction counter.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every buffered entry (and any push in the same cycle)
//   in_valid/in_ready input handshake; in_inst = instruction word, in_pc = its PC
//   out_valid/out_ready output handshake for the FIFO head entry
//   out_pc, out_imm   PC and sign-extended immediate of the head entry
//   out_rs1/rs2/rd    register indices (0 when the type does not use them)
//   out_rd_we         rd is written (R/I/U/UJ with rd != 0)
//   out_type          R=0 I=1 S=2 SB=3 UJ=4 U=5
//   out_control       {opcode, funct3, funct7}
//   out_illegal       opcode not recognised
//   illegal_count     illegal instructions accepted so far, saturating
module decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_imm,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic             out_rd_we,
   output logic [2:0]       out_type,
   output logic [16:0]      out_control,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   localparam logic [2:0] TypeR  = 3'd0;
   localparam logic [2:0] TypeI  = 3'd1;
   localparam logic [2:0] TypeS  = 3'd2;
   localparam logic [2:0] TypeSB = 3'd3;
   localparam logic [2:0] TypeUJ = 3'd4;
   localparam logic [2:0] TypeU  = 3'd5;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpImm32  = 7'b0011011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpSystem = 7'b1110011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpReg32  = 7'b0111011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            rd_we;
      logic [2:0]      itype;
      logic [16:0]     control;
      logic            illegal;
   } entry_t;

   // ---------------------------------------------------------------- decode
   entry_t      dec;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [2:0]  itype;
   logic        illegal;
   logic [31:0] imm32;
   logic        use_rd, use_rs1, use_rs2, keep_f3, keep_f7;

   always_comb begin
      opcode  = in_inst[6:0];
      funct3  = in_inst[14:12];
      funct7  = in_inst[31:25];
      itype   = TypeR;
      illegal = 1'b0;
      case (opcode)
         OpLoad, OpImm, OpImm32, OpJalr, OpSystem: itype = TypeI;
         OpReg, OpReg32:                           itype = TypeR;
         OpStore:                                  itype = TypeS;
         OpBranch:                                 itype = TypeSB;
         OpJal:                                    itype = TypeUJ;
         OpLui, OpAuipc:                           itype = TypeU;
         default:                                  illegal = 1'b1;
      endcase

      imm32   = '0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      keep_f3 = 1'b0;
      keep_f7 = 1'b0;
      // Illegal entries keep every field at zero except the opcode.
      if (!illegal) begin
         case (itype)
            TypeR: begin
               use_rd  = 1'b1;
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
               keep_f3 = 1'b1;
               keep_f7 = 1'b1;
            end
            TypeI: begin
               use_rd  = 1'b1;
               use_rs1 = 1'b1;
               keep_f3 = 1'b1;
               // Immediate shifts carry funct7 in the upper immediate bits.
               keep_f7 = ((opcode == OpImm) || (opcode == OpImm32)) &&
                         ((funct3 == 3'b001) || (funct3 == 3'b101));
               imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            TypeS: begin
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
               keep_f3 = 1'b1;
               imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            TypeSB: begin
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
               keep_f3 = 1'b1;
               imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                          in_inst[11:8], 1'b0};
            end
            TypeUJ: begin
               use_rd = 1'b1;
               imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                         in_inst[30:21], 1'b0};
            end
            TypeU: begin
               use_rd = 1'b1;
               imm32  = {in_inst[31:12], 12'b0};
            end
            default: ;
         endcase
      end

      dec         = '0;
      dec.pc      = in_pc;
      dec.imm     = XLEN'($signed(imm32));
      dec.rs1     = use_rs1 ? in_inst[19:15] : 5'd0;
      dec.rs2     = use_rs2 ? in_inst[24:20] : 5'd0;
      dec.rd      = use_rd ? in_inst[11:7] : 5'd0;
      dec.rd_we   = use_rd && (in_inst[11:7] != 5'd0);
      dec.itype   = itype;
      dec.control = {opcode, keep_f3 ? funct3 : 3'd0, keep_f7 ? funct7 : 7'd0};
      dec.illegal = illegal;
   end

   // ---------------------------------------------------------------- output FIFO
   entry_t           mem_q [DEPTH];
   entry_t           out_q, out_d;
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CNT_W-1:0] illegal_count_q;
   logic             push, pop;

   assign in_ready  = ~rst & (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   // out_q mirrors the entry that will be at the head after this edge, so the outputs come
   // straight from flops and simply hold their last values once the FIFO drains.
   always_comb begin
      out_d = out_q;
      if ((count_q - CW'(pop)) != '0) begin
         out_d = mem_q[rd_ptr_q + PW'(pop)];
      end else if (push) begin
         out_d = dec;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         illegal_count_q <= '0;
         out_q           <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
         if (push && dec.illegal && (illegal_count_q != '1)) begin
            illegal_count_q <= illegal_count_q + CNT_W'(1);
         end
         out_q <= out_d;
      end
   end

   assign out_pc        = out_q.pc;
   assign out_imm       = out_q.imm;
   assign out_rs1       = out_q.rs1;
   assign out_rs2       = out_q.rs2;
   assign out_rd        = out_q.rd;
   assign out_rd_we     = out_q.rd_we;
   assign out_type      = out_q.itype;
   assign out_control   = out_q.control;
   assign out_illegal   = out_q.illegal;
   assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected decodes (from a behavioural
// model of the RV32 field rules) into a queue; a separate monitor pops and compares.
module tb_decode_stage;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   localparam int CNT_W = 3;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc, out_pc, out_imm;
   logic [4:0]       out_rs1, out_rs2, out_rd;
   logic             out_rd_we, out_illegal;
   logic [2:0]       out_type;
   logic [16:0]      out_control;
   logic [CNT_W-1:0] illegal_count;

   decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
      .out_type(out_type), .out_control(out_control), .out_illegal(out_illegal),
      .illegal_count(illegal_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic        rd_we;
      logic [2:0]  typ;
      logic [16:0] control;
      logic        illegal;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          model_cnt = 0;
   bit          prev_rst = 1'b0;
   logic [31:0] pc_ctr = 32'h0000_1000;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Field rules written directly from the ISA encoding, using integer arithmetic.
   function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
      exp_t       e;
      int         t, s, imm;
      bit         ill, ur, u1, u2;
      logic [6:0] op, f7;
      logic [2:0] f3;
      op  = inst[6:0];
      s   = $signed(inst);
      ill = 1'b0;
      t   = 0;
      case (op)
         7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: t = 1;
         7'h33, 7'h3B:                      t = 0;
         7'h23:                             t = 2;
         7'h63:                             t = 3;
         7'h6F:                             t = 4;
         7'h37, 7'h17:                      t = 5;
         default:                           ill = 1'b1;
      endcase
      case (t)
         1:       imm = s >>> 20;
         2:       imm = (s >>> 25) * 32 + int'(inst[11:7]);
         3:       imm = (s >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 +
                        int'(inst[11:8]) * 2;
         4:       imm = (s >>> 31) * 1048576 + int'(inst[19:12]) * 4096 +
                        int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
         5:       imm = s & 32'hFFFF_F000;
         default: imm = 0;
      endcase
      if (ill) imm = 0;
      ur = !ill && (t inside {0, 1, 4, 5});
      u1 = !ill && (t inside {0, 1, 2, 3});
      u2 = !ill && (t inside {0, 2, 3});
      f3 = (!ill && t <= 3) ? inst[14:12] : 3'd0;
      f7 = (!ill && (t == 0 || ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5))))
           ? inst[31:25] : 7'd0;
      e.pc      = pc;
      e.imm     = imm;
      e.rs1     = u1 ? inst[19:15] : 5'd0;
      e.rs2     = u2 ? inst[24:20] : 5'd0;
      e.rd      = ur ? inst[11:7] : 5'd0;
      e.rd_we   = ur && (inst[11:7] != 5'd0);
      e.typ     = 3'(t);
      e.control = {op, f3, f7};
      e.illegal = ill;
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      logic [6:0]  op;
      logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h33, 7'h3B, 7'h23,
                                7'h63, 7'h6F, 7'h37, 7'h17};
      r = $urandom;
      if ($urandom_range(0, 99) < 15) op = 7'($urandom);
      else op = ops[$urandom_range(0, 11)];
      return {r[31:7], op};
   endfunction

   // One clock: drive at +1, check state visible since the edge at +2, book the transfer
   // that the coming edge will perform at the falling edge.
   task automatic cycle(input bit v, input logic [31:0] inst, input bit rdy, input bit fl,
                        input bit rs, output bit acc);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc_ctr;
      out_ready = rdy;
      flush     = fl;
      rst       = rs;
      #1;
      if (prev_rst) begin
         check("rst_out_pc", out_pc, 32'd0);
         check("rst_out_imm", out_imm, 32'd0);
         check("rst_out_regs", 32'({out_rs1, out_rs2, out_rd, out_rd_we}), 32'd0);
         check("rst_out_type", 32'(out_type), 32'd0);
         check("rst_out_control", 32'(out_control), 32'd0);
         check("rst_out_illegal", 32'(out_illegal), 32'd0);
      end
      check("in_ready", 32'(in_ready), 32'(!rs && q.size() < DEPTH));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("illegal_count", 32'(illegal_count), 32'(model_cnt));
      acc = v && !rs && !fl && (q.size() < DEPTH);
      @(negedge clk);
      prev_rst = rs;
      if (rs) begin
         q.delete();
         model_cnt = 0;
      end else if (fl) begin
         q.delete();
      end else if (acc) begin
         e = model(inst, pc_ctr);
         q.push_back(e);
         if (e.illegal && model_cnt < CMAX) model_cnt++;
      end
      if (acc) pc_ctr += 32'd4;
   endtask

   task automatic push_inst(input logic [31:0] inst, input bit rdy);
      bit acc;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, inst, rdy, 1'b0, 1'b0, acc);
         if (acc) return;
      end
      errors++;
      checks++;
      $display("FAIL push_timeout: got no acceptance expected acceptance of %h", inst);
   endtask

   task automatic idle(input bit rdy);
      bit acc;
      cycle(1'b0, 32'd0, rdy, 1'b0, 1'b0, acc);
   endtask

   // Monitor: compare the head entry whenever the consumer takes it.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && !flush && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got pc %h expected no output", out_pc);
         end else begin
            e = q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_imm", out_imm, e.imm);
            check("out_rs1", 32'(out_rs1), 32'(e.rs1));
            check("out_rs2", 32'(out_rs2), 32'(e.rs2));
            check("out_rd", 32'(out_rd), 32'(e.rd));
            check("out_rd_we", 32'(out_rd_we), 32'(e.rd_we));
            check("out_type", 32'(out_type), 32'(e.typ));
            check("out_control", 32'(out_control), 32'(e.control));
            check("out_illegal", 32'(out_illegal), 32'(e.illegal));
         end
      end
   end

   initial begin
      bit acc;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_pc = '0;

      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
      idle(1'b0);

      // addi x1,x0,-1
      push_inst(32'hFFF0_0093, 1'b0);
      idle(1'b0);
      check("addi_type", 32'(out_type), 32'd1);
      check("addi_rd", 32'(out_rd), 32'd1);
      check("addi_rs1", 32'(out_rs1), 32'd0);
      check("addi_imm", out_imm, 32'hFFFF_FFFF);
      check("addi_rd_we", 32'(out_rd_we), 32'd1);
      idle(1'b1);

      // sw x5,8(x2)
      push_inst(32'h0051_2423, 1'b0);
      idle(1'b0);
      check("sw_type", 32'(out_type), 32'd2);
      check("sw_regs", 32'({out_rs1, out_rs2, out_rd}), 32'({5'd2, 5'd5, 5'd0}));
      check("sw_imm", out_imm, 32'h8);
      check("sw_rd_we", 32'(out_rd_we), 32'd0);
      idle(1'b1);

      // beq x1,x2,-4 then jal x1,2048
      push_inst(32'hFE20_8EE3, 1'b0);
      idle(1'b0);
      check("beq_type", 32'(out_type), 32'd3);
      check("beq_imm", out_imm, 32'hFFFF_FFFC);
      idle(1'b1);
      push_inst(32'h0010_00EF, 1'b0);
      idle(1'b0);
      check("jal_type", 32'(out_type), 32'd4);
      check("jal_imm", out_imm, 32'h800);
      idle(1'b1);

      // illegal all-zero word, then lui
      push_inst(32'h0000_0000, 1'b0);
      idle(1'b0);
      check("zero_illegal", 32'(out_illegal), 32'd1);
      check("zero_count", 32'(illegal_count), 32'd1);
      idle(1'b1);
      push_inst(32'h1234_50B7, 1'b0);
      idle(1'b0);
      check("lui_type", 32'(out_type), 32'd5);
      check("lui_imm", out_imm, 32'h1234_5000);
      idle(1'b1);

      // back-pressure: third push must wait until the consumer releases
      push_inst(32'h0020_8133, 1'b0);
      push_inst(32'h00A0_0193, 1'b0);
      cycle(1'b1, 32'h4030_5233, 1'b0, 1'b0, 1'b0, acc);
      check("full_accept", 32'(acc), 32'd0);
      push_inst(32'h4030_5233, 1'b1);
      repeat (3) idle(1'b1);

      // flush with one buffered entry and a push in the same cycle
      push_inst(32'h0041_8293, 1'b0);
      cycle(1'b1, 32'h0050_0313, 1'b1, 1'b1, 1'b0, acc);
      repeat (3) idle(1'b1);

      // reset with a full FIFO
      push_inst(32'h0000_0000, 1'b0);
      push_inst(32'h0010_0393, 1'b0);
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
      idle(1'b0);
      idle(1'b1);

      // counter saturation
      for (int i = 0; i < CMAX + 2; i++) push_inst({rand_inst() & 32'hFFFF_FF80} | 32'h7F, 1'b1);
      repeat (3) idle(1'b1);
      check("count_saturated", 32'(illegal_count), 32'(CMAX));

      // randomized traffic with occasional flush and reset
      for (int i = 0; i < 500; i++) begin
         cycle(($urandom_range(0, 99) < 70), rand_inst(), ($urandom_range(0, 99) < 60),
               ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) < 2), acc);
      end

      for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
      if (q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got %0d entries left expected 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
